// File: rtl/pixel_point_op_stream.sv
// Streaming per-pixel point operations (add/sub/threshold/invert/pass) behind a 2-stage valid/ready
// pipeline with frame tracking. Optional saturation counter enabled by `define PIXOP_SAT_COUNT_EN.
module pixel_point_op_stream #(
  parameter  int PIX_W     = 8,
  parameter  int CHANNELS  = 1,
  parameter  int FRAME_PIX = 98304,
  localparam int CNT_W     = $clog2(FRAME_PIX + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [2:0]                cfg_mode,
  input  logic [PIX_W-1:0]          cfg_value,
  input  logic [PIX_W-1:0]          cfg_threshold,
  input  logic                      cfg_load,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [CHANNELS*PIX_W-1:0] s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [CHANNELS*PIX_W-1:0] m_data,
  output logic                      m_last,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      cfg_err,
  output logic [CNT_W-1:0]          sat_count
);

  localparam int                DW        = CHANNELS * PIX_W;
  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(FRAME_PIX - 1);
  localparam logic [PIX_W-1:0]  PIX_MAX   = {PIX_W{1'b1}};
  localparam logic [PIX_W-1:0]  PIX_ZERO  = {PIX_W{1'b0}};
  localparam logic [2:0]        MODE_ADD  = 3'b000;
  localparam logic [2:0]        MODE_SUB  = 3'b001;
  localparam logic [2:0]        MODE_THR  = 3'b010;
  localparam logic [2:0]        MODE_INV  = 3'b011;
  localparam logic [2:0]        MODE_PASS = 3'b100;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_nx_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [2:0]        mode_r;
  logic [PIX_W-1:0]  value_r;
  logic [PIX_W-1:0]  thresh_r;
  logic              v1_r;
  logic              l1_r;
  logic [DW-1:0]     d1_r;
  logic              v2_r;
  logic              l2_r;
  logic [DW-1:0]     d2_r;
  logic [DW-1:0]     res_s;
  logic              en1_s;
  logic              en2_s;
  logic              in_hs_s;
  logic              out_hs_s;
  logic              last_s;
  logic              cfg_err_r;
  logic              frame_done_r;

  function automatic logic [PIX_W-1:0] point_op(input logic [2:0]       mode,
                                                 input logic [PIX_W-1:0] x,
                                                 input logic [PIX_W-1:0] v,
                                                 input logic [PIX_W-1:0] thr);
    logic [PIX_W:0] sum;
    sum = {1'b0, x} + {1'b0, v};
    case (mode)
      MODE_ADD: point_op = sum[PIX_W] ? PIX_MAX : sum[PIX_W-1:0];
      MODE_SUB: point_op = (x < v) ? PIX_ZERO : (x - v);
      MODE_THR: point_op = (x >= thr) ? PIX_MAX : PIX_ZERO;
      MODE_INV: point_op = PIX_MAX - x;
      default:  point_op = x;
    endcase
  endfunction

  // Stage 2 drains on downstream ready; stage 1 may refill whenever stage 2 frees up.
  assign en2_s    = ~v2_r | m_ready;
  assign en1_s    = ~v1_r | en2_s;
  assign s_ready  = en1_s;
  assign in_hs_s  = s_valid & en1_s;
  assign out_hs_s = v2_r & m_ready;
  assign last_s   = (cnt_r == LAST_IDX);

  // Per-channel point operation on the incoming beat
  always_comb begin
    res_s = {DW{1'b0}};
    for (int c = 0; c < CHANNELS; c++) begin
      res_s[c*PIX_W +: PIX_W] = point_op(mode_r, s_data[c*PIX_W +: PIX_W], value_r, thresh_r);
    end
  end

  // Frame FSM next state; with a single-pixel frame every beat is last and the FSM never leaves IDLE
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_hs_s && !last_s) state_nx_s = ST_ACTIVE;
        else                    state_nx_s = ST_IDLE;
      end
      ST_ACTIVE: begin
        if (in_hs_s && last_s) state_nx_s = ST_IDLE;
        else                   state_nx_s = ST_ACTIVE;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Frame FSM state register and pixel counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nx_s;
      if (in_hs_s) begin
        cnt_r <= last_s ? {CNT_W{1'b0}} : (cnt_r + CNT_W'(1));
      end
    end
  end

  // Shadow configuration: only reloaded between frames so a frame is processed uniformly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r    <= MODE_PASS;
      value_r   <= {PIX_W{1'b0}};
      thresh_r  <= {PIX_W{1'b0}};
      cfg_err_r <= 1'b0;
    end else begin
      cfg_err_r <= cfg_load & (state_r == ST_ACTIVE);
      if (cfg_load && (state_r == ST_IDLE)) begin
        mode_r   <= cfg_mode;
        value_r  <= cfg_value;
        thresh_r <= cfg_threshold;
      end
    end
  end

  // Two-stage pipeline; last flag is cleared on bubbles so m_last never appears without m_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r <= 1'b0;
      l1_r <= 1'b0;
      d1_r <= {DW{1'b0}};
      v2_r <= 1'b0;
      l2_r <= 1'b0;
      d2_r <= {DW{1'b0}};
    end else begin
      if (en1_s) begin
        v1_r <= in_hs_s;
        if (in_hs_s) begin
          d1_r <= res_s;
          l1_r <= last_s;
        end
      end
      if (en2_s) begin
        v2_r <= v1_r;
        l2_r <= v1_r & l1_r;
        if (v1_r) begin
          d2_r <= d1_r;
        end
      end
    end
  end

  // End-of-frame pulse, one cycle after the last beat leaves
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= out_hs_s & l2_r;
    end
  end

  assign m_valid    = v2_r;
  assign m_data     = d2_r;
  assign m_last     = l2_r;
  assign busy       = (state_r == ST_ACTIVE) | v1_r | v2_r;
  assign frame_done = frame_done_r;
  assign cfg_err    = cfg_err_r;

`ifdef PIXOP_SAT_COUNT_EN
  localparam int               CH_W        = $clog2(CHANNELS);
  localparam int               SAT_W       = CNT_W + CH_W;
  localparam int               BC_W        = $clog2(CHANNELS + 1);
  localparam logic [SAT_W-1:0] SAT_CNT_MAX = SAT_W'({CNT_W{1'b1}});

  logic [BC_W-1:0]  beat_sat_s;
  logic [BC_W-1:0]  bs1_r;
  logic [BC_W-1:0]  bs2_r;
  logic [SAT_W-1:0] sat_acc_r;
  logic [SAT_W:0]   sat_sum_s;
  logic [SAT_W-1:0] sat_tot_s;
  logic [CNT_W-1:0] sat_count_r;

  function automatic logic clamps(input logic [2:0]       mode,
                                  input logic [PIX_W-1:0] x,
                                  input logic [PIX_W-1:0] v);
    logic [PIX_W:0] sum;
    sum = {1'b0, x} + {1'b0, v};
    case (mode)
      MODE_ADD: clamps = sum[PIX_W];
      MODE_SUB: clamps = (x < v);
      default:  clamps = 1'b0;
    endcase
  endfunction

  // Clamped samples in the incoming beat; the count rides with the beat so frames stay separated
  always_comb begin
    beat_sat_s = {BC_W{1'b0}};
    for (int c = 0; c < CHANNELS; c++) begin
      beat_sat_s = beat_sat_s + BC_W'(clamps(mode_r, s_data[c*PIX_W +: PIX_W], value_r));
    end
  end

  // Saturating running total including the beat at the output
  always_comb begin
    sat_sum_s = {1'b0, sat_acc_r} + (SAT_W+1)'(bs2_r);
    if (sat_sum_s[SAT_W]) sat_tot_s = {SAT_W{1'b1}};
    else                  sat_tot_s = sat_sum_s[SAT_W-1:0];
  end

  // Per-beat counts through the pipeline, frame accumulation, publish on the last beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bs1_r       <= {BC_W{1'b0}};
      bs2_r       <= {BC_W{1'b0}};
      sat_acc_r   <= {SAT_W{1'b0}};
      sat_count_r <= {CNT_W{1'b0}};
    end else begin
      if (in_hs_s) begin
        bs1_r <= beat_sat_s;
      end
      if (en2_s && v1_r) begin
        bs2_r <= bs1_r;
      end
      if (out_hs_s) begin
        if (l2_r) begin
          sat_acc_r   <= {SAT_W{1'b0}};
          sat_count_r <= (sat_tot_s > SAT_CNT_MAX) ? {CNT_W{1'b1}} : sat_tot_s[CNT_W-1:0];
        end else begin
          sat_acc_r <= sat_tot_s;
        end
      end
    end
  end

  assign sat_count = sat_count_r;
`else
  assign sat_count = {CNT_W{1'b0}};
`endif

endmodule
